// File: rtl/coreuart_tx_fifo_gen2.sv
// coreuart_tx_fifo_gen2: UART transmitter with synchronous TX FIFO, optional line break via TX_BREAK_EN
module coreuart_tx_fifo_gen2 #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              xmit_pulse,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        char_len,
  input  logic              parity_en,
  input  logic              odd_n_even,
  input  logic              two_stop,
`ifdef TX_BREAK_EN
  input  logic              break_req,
`endif
  output logic              tx,
  output logic              tx_busy,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] MAX_LEN = 4'(DATA_W);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  logic brk;
`ifdef TX_BREAK_EN
  assign brk = break_req;
`else
  assign brk = 1'b0;
`endif
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic overflow_q, overflow_d, push, pop;
  state_t state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [3:0] idx_q, idx_d, len_q, len_d;
  logic par_q, par_d, pen_q, pen_d, odd_q, odd_d, two_q, two_d, tx_q, tx_d;
  assign fifo_empty = count_q == '0;
  assign fifo_full = count_q == LVL_W'(FIFO_DEPTH);
  assign fifo_level = count_q;
  assign overflow = overflow_q;
  assign tx = tx_q;
  assign tx_busy = state_q != IDLE;
  assign push = wr_en && !fifo_full;
  always_comb begin
    overflow_d = wr_en && fifo_full;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = count_q + LVL_W'(push) - LVL_W'(pop);
  end
  always_comb begin
    state_d = state_q;
    tx_d = tx_q;
    shift_d = shift_q;
    idx_d = idx_q;
    par_d = par_q;
    len_d = len_q;
    pen_d = pen_q;
    odd_d = odd_q;
    two_d = two_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = !brk;
        if (!fifo_empty && !brk) begin
          pop = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          len_d = char_len < 4'd5 ? 4'd5 : char_len > MAX_LEN ? MAX_LEN : char_len;
          pen_d = parity_en;
          odd_d = odd_n_even;
          two_d = two_stop;
          state_d = START;
        end
      end
      START: if (xmit_pulse) begin
        tx_d = 1'b0;
        idx_d = '0;
        par_d = 1'b0;
        state_d = DATA;
      end
      DATA: if (xmit_pulse) begin
        tx_d = shift_q[0];
        par_d = par_q ^ shift_q[0];
        shift_d = shift_q >> 1;
        idx_d = idx_q + 4'd1;
        state_d = idx_q == len_q - 4'd1 ? (pen_q ? PARITY : STOP1) : DATA;
      end
      PARITY: if (xmit_pulse) begin
        tx_d = par_q ^ odd_q;
        state_d = STOP1;
      end
      STOP1: if (xmit_pulse) begin
        tx_d = 1'b1;
        state_d = two_q ? STOP2 : IDLE;
      end
      STOP2: if (xmit_pulse) begin
        tx_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= wr_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
      state_q <= IDLE;
      tx_q <= 1'b1;
      shift_q <= '0;
      idx_q <= '0;
      par_q <= 1'b0;
      len_q <= MAX_LEN;
      pen_q <= 1'b0;
      odd_q <= 1'b0;
      two_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
      state_q <= state_d;
      tx_q <= tx_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      par_q <= par_d;
      len_q <= len_d;
      pen_q <= pen_d;
      odd_q <= odd_d;
      two_q <= two_d;
    end
  end
endmodule

// File: tb/tb_coreuart_tx_fifo_gen2.sv
// tb_coreuart_tx_fifo_gen2: directed self-checking bench for coreuart_tx_fifo_gen2
module tb_coreuart_tx_fifo_gen2;
  localparam int DW = 8;
  localparam int FD = 16;
  localparam int LW = $clog2(FD) + 1;
  logic clk = 0, reset = 1, xmit_pulse = 0, wr_en = 0;
  logic parity_en = 0, odd_n_even = 0, two_stop = 0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0] char_len = 4'd8;
  logic tx, tx_busy, fifo_empty, fifo_full, overflow;
  logic [LW-1:0] fifo_level;
`ifdef TX_BREAK_EN
  logic break_req = 0;
`endif
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  coreuart_tx_fifo_gen2 #(.DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .xmit_pulse(xmit_pulse), .wr_en(wr_en), .wr_data(wr_data),
    .char_len(char_len), .parity_en(parity_en), .odd_n_even(odd_n_even), .two_stop(two_stop),
`ifdef TX_BREAK_EN
    .break_req(break_req),
`endif
    .tx(tx), .tx_busy(tx_busy), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_level(fifo_level), .overflow(overflow)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [DW-1:0] d);
    wr_data = d;
    wr_en = 1;
    tick;
    wr_en = 0;
  endtask
  task automatic cfg(input logic [3:0] len, input logic pen, input logic odd, input logic two);
    char_len = len;
    parity_en = pen;
    odd_n_even = odd;
    two_stop = two;
  endtask
  task automatic frame(input string tag, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      xmit_pulse = 1;
      tick;
      xmit_pulse = 0;
      check(tag, tx, bits[i]);
      check({tag, "_busy"}, tx_busy, i < n - 1);
      tick;
      tick;
      check({tag, "_hold"}, tx, bits[i]);
    end
  endtask
  initial begin
    int ov_cnt;
    tick;
    tick;
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    reset = 0;
    tick;
    cfg(4'd8, 0, 0, 0);
    push(8'hA5);
    check("t1_level1", fifo_level, 1);
    check("t1_empty0", fifo_empty, 0);
    tick;
    check("t1_busy", tx_busy, 1);
    check("t1_level0", fifo_level, 0);
    check("t1_tx_idle", tx, 1);
    frame("t1", 16'h034A, 10);
    cfg(4'd7, 1, 1, 1);
    push(8'h07);
    tick;
    frame("t2", 16'h060E, 11);
    check("t2_busy_end", tx_busy, 0);
    cfg(4'd3, 0, 0, 0);
    push(8'hFF);
    tick;
    frame("t5", 16'h007E, 7);
    cfg(4'd8, 0, 0, 0);
    push(8'hC3);
    tick;
    ov_cnt = 0;
    for (int i = 0; i <= FD; i++) begin
      wr_data = DW'(8'h10 + i);
      wr_en = 1;
      tick;
      ov_cnt += int'(overflow);
    end
    wr_en = 0;
    tick;
    ov_cnt += int'(overflow);
    check("t3_ovf_cnt", ov_cnt, 1);
    check("t3_full", fifo_full, 1);
    check("t3_level", fifo_level, FD);
    frame("t3_f0", {6'b0, 1'b1, 8'hC3, 1'b0}, 10);
    for (int i = 0; i < FD; i++) frame("t3_fn", {6'b0, 1'b1, 8'(8'h10 + i), 1'b0}, 10);
    check("t3_empty_end", fifo_empty, 1);
    check("t3_busy_end", tx_busy, 0);
    push(8'h00);
    push(8'h00);
    tick;
    check("t4_level", fifo_level, 1);
    for (int i = 0; i < 5; i++) begin
      xmit_pulse = 1;
      tick;
      xmit_pulse = 0;
      tick;
    end
    check("t4_tx_pre", tx, 0);
    reset = 1;
    tick;
    reset = 0;
    check("t4_tx", tx, 1);
    check("t4_level0", fifo_level, 0);
    check("t4_busy", tx_busy, 0);
    for (int i = 0; i < 4; i++) begin
      xmit_pulse = 1;
      tick;
      xmit_pulse = 0;
      tick;
      check("t4_quiet_tx", tx, 1);
      check("t4_quiet_busy", tx_busy, 0);
    end
`ifdef TX_BREAK_EN
    push(8'h55);
    push(8'h0F);
    tick;
    break_req = 1;
    for (int i = 0; i < 10; i++) begin
      logic [15:0] b;
      b = {6'b0, 1'b1, 8'h55, 1'b0};
      xmit_pulse = 1;
      tick;
      xmit_pulse = 0;
      check("brk_f1", tx, b[i]);
      tick;
    end
    check("brk_tx0", tx, 0);
    check("brk_busy", tx_busy, 0);
    check("brk_level", fifo_level, 1);
    for (int i = 0; i < 3; i++) begin
      xmit_pulse = 1;
      tick;
      xmit_pulse = 0;
      tick;
    end
    check("brk_hold_tx", tx, 0);
    check("brk_hold_level", fifo_level, 1);
    break_req = 0;
    tick;
    check("brk_rel_tx", tx, 1);
    check("brk_rel_busy", tx_busy, 1);
    frame("brk_f2", {6'b0, 1'b1, 8'h0F, 1'b0}, 10);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
